am_mem_server: RTL

Server endpoint of the active-message channel: terminates client requests on the server-side channel signals and services them against a local word-addressed memory. Queues incoming requests, executes read/write/echo, and returns one response per accepted request with source/destination swapped and user arguments echoed. Sits behind any client that drives the request side and pops the response side.

---
 rtl/am_mem_server_if.sv | 27 ++
 rtl/am_mem_server.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/am_mem_server_if.sv
// Active-message channel as seen by the server endpoint: request push side plus
// first-word-fall-through response side.
interface am_mem_server_if #(
  parameter int SDARG_BITS = 32,
  parameter int DATA_BITS  = 512
);
  localparam int W = DATA_BITS + 6 * SDARG_BITS;

  logic         tx;
  logic [W-1:0] tx_msg;
  logic         tx_full;
  logic         tx_almost_full;
  logic         rx_empty;
  logic [W-1:0] rx_msg;
  logic         rx_pop;
  logic [15:0]  drop_cnt;

  modport master (
    output tx, tx_msg, rx_pop,
    input  tx_full, tx_almost_full, rx_empty, rx_msg, drop_cnt
  );

  modport slave (
    input  tx, tx_msg, rx_pop,
    output tx_full, tx_almost_full, rx_empty, rx_msg, drop_cnt
  );
endinterface

// File: rtl/am_mem_server.sv
// Active-message server: queues requests, runs READ/WRITE/ECHO against a local
// word memory and returns one response per accepted request.
module am_mem_server #(
  parameter int SDARG_BITS = 32,
  parameter int DATA_BITS  = 512,
  parameter int REQ_DEPTH  = 8,
  parameter int RSP_DEPTH  = 8,
  parameter int MEM_WORDS  = 256,
  parameter int AF_MARGIN  = 2
) (
  input logic           clk,
  input logic           rst_n,
  am_mem_server_if.slave am
);
  localparam int S   = SDARG_BITS;
  localparam int W   = DATA_BITS + 6 * S;
  localparam int RAW = $clog2(REQ_DEPTH);
  localparam int RSW = $clog2(RSP_DEPTH);
  localparam int MAW = $clog2(MEM_WORDS);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ECHO  = 2'd2;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  logic [W-1:0]         req_mem [REQ_DEPTH];
  logic [W-1:0]         rsp_mem [RSP_DEPTH];
  logic [DATA_BITS-1:0] ram     [MEM_WORDS];
  logic [DATA_BITS-1:0] ram_rdata;

  logic [RAW-1:0] req_wp_q, req_wp_d, req_rp_q, req_rp_d;
  logic [RAW:0]   req_cnt_q, req_cnt_d;
  logic [RSW-1:0] rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  logic [RSW:0]   rsp_cnt_q, rsp_cnt_d;
  logic [15:0]    drop_q, drop_d;
  logic [W-1:0]   hd_q, hd_d;
  state_e         state_q, state_d;

  logic req_push_s, req_pop_s, rsp_push_s, rsp_pop_s;
  logic can_issue_s, mem_we_s, mem_re_s;
  logic [W-1:0]         head_s, rsp_msg_s;
  logic [1:0]           head_op_s, hd_op_s, status_s;
  logic [S-1:0]         head_addr_s, hd_addr_s;
  logic                 head_in_range_s, hd_in_range_s;
  logic [DATA_BITS-1:0] rsp_data_s;
  logic                 unused_arg0_s;

  assign am.tx_full        = (req_cnt_q == (RAW+1)'(REQ_DEPTH));
  assign am.tx_almost_full = (req_cnt_q >= (RAW+1)'(REQ_DEPTH - AF_MARGIN));
  assign am.rx_empty       = (rsp_cnt_q == {(RSW+1){1'b0}});
  assign am.rx_msg         = am.rx_empty ? {W{1'b0}} : rsp_mem[rsp_rp_q];
  assign am.drop_cnt       = drop_q;

  assign head_s          = req_mem[req_rp_q];
  assign head_op_s       = head_s[3*S +: 2];
  assign head_addr_s     = head_s[2*S +: S];
  assign head_in_range_s = (head_addr_s < S'(MEM_WORDS));
  assign hd_op_s         = hd_q[3*S +: 2];
  assign hd_addr_s       = hd_q[2*S +: S];
  assign hd_in_range_s   = (hd_addr_s < S'(MEM_WORDS));
  assign unused_arg0_s   = ^hd_q[3*S+2 +: S-2];

  assign req_push_s = am.tx && !am.tx_full;
  assign rsp_pop_s  = am.rx_pop && !am.rx_empty;
  // Only IDLE issues, and nothing is in flight then, so a free slot is enough.
  assign can_issue_s = (req_cnt_q != {(RAW+1){1'b0}}) &&
                       (((RSW+2)'(rsp_cnt_q) + (RSW+2)'(state_q == ACCESS)) < (RSW+2)'(RSP_DEPTH));
  assign mem_we_s = req_pop_s && rst_n && (head_op_s == OP_WRITE) && head_in_range_s;
  assign mem_re_s = req_pop_s && rst_n && (head_op_s == OP_READ) && head_in_range_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (can_issue_s) state_d = ACCESS;
        else             state_d = IDLE;
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_pop_s  = 1'b0;
    rsp_push_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_issue_s) req_pop_s = 1'b1;
        else             req_pop_s = 1'b0;
      end
      ACCESS:  rsp_push_s = 1'b1;
      default: req_pop_s  = 1'b0;
    endcase
  end

  // FIFO pointers, occupancies, head latch and drop counter next values
  always_comb begin
    req_wp_d  = req_push_s ? req_wp_q + {{(RAW-1){1'b0}}, 1'b1} : req_wp_q;
    req_rp_d  = req_pop_s  ? req_rp_q + {{(RAW-1){1'b0}}, 1'b1} : req_rp_q;
    req_cnt_d = req_cnt_q + (RAW+1)'(req_push_s) - (RAW+1)'(req_pop_s);
    rsp_wp_d  = rsp_push_s ? rsp_wp_q + {{(RSW-1){1'b0}}, 1'b1} : rsp_wp_q;
    rsp_rp_d  = rsp_pop_s  ? rsp_rp_q + {{(RSW-1){1'b0}}, 1'b1} : rsp_rp_q;
    rsp_cnt_d = rsp_cnt_q + (RSW+1)'(rsp_push_s) - (RSW+1)'(rsp_pop_s);
    hd_d      = req_pop_s ? head_s : hd_q;
    if (am.tx && am.tx_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    else                                             drop_d = drop_q;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_wp_q  <= {RAW{1'b0}};
      req_rp_q  <= {RAW{1'b0}};
      req_cnt_q <= {(RAW+1){1'b0}};
      rsp_wp_q  <= {RSW{1'b0}};
      rsp_rp_q  <= {RSW{1'b0}};
      rsp_cnt_q <= {(RSW+1){1'b0}};
      drop_q    <= 16'd0;
      hd_q      <= {W{1'b0}};
    end else begin
      req_wp_q  <= req_wp_d;
      req_rp_q  <= req_rp_d;
      req_cnt_q <= req_cnt_d;
      rsp_wp_q  <= rsp_wp_d;
      rsp_rp_q  <= rsp_rp_d;
      rsp_cnt_q <= rsp_cnt_d;
      drop_q    <= drop_d;
      hd_q      <= hd_d;
    end
  end

  // Request and response FIFO storage
  always_ff @(posedge clk) begin
    if (req_push_s) req_mem[req_wp_q] <= am.tx_msg;
    if (rsp_push_s) rsp_mem[rsp_wp_q] <= rsp_msg_s;
  end

  // Single-port local memory, one-cycle read latency, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) ram[head_addr_s[MAW-1:0]] <= head_s[6*S +: DATA_BITS];
    if (mem_re_s) ram_rdata <= ram[head_addr_s[MAW-1:0]];
  end

  // Response assembly from the latched request and the memory read port
  always_comb begin
    status_s   = 2'd0;
    rsp_data_s = {DATA_BITS{1'b0}};
    case (hd_op_s)
      OP_READ: begin
        if (hd_in_range_s) rsp_data_s = ram_rdata;
        else               status_s   = 2'd2;
      end
      OP_WRITE: begin
        if (hd_in_range_s) status_s = 2'd0;
        else               status_s = 2'd2;
      end
      OP_ECHO: rsp_data_s = hd_q[6*S +: DATA_BITS];
      default: status_s   = 2'd1;
    endcase
    rsp_msg_s = {rsp_data_s, hd_q[4*S +: S], hd_q[5*S +: S],
                 {(S-2){1'b0}}, status_s, hd_q[0 +: 3*S]};
  end
endmodule
